regfile_lx: RTL and testbench

- Parametrised next-generation register file for the pipeline.
- Two combinational read ports plus a jump-register target output.
- One write port with a load-extract unit supporting lb/lbu/lh/lhu/lw, and a dedicated link-register write for jal.
- A per-register pending-load scoreboard that decode uses to generate stalls.
- Sits between decode (reads, scoreboard set) and writeback (writes, scoreboard clear).

---
 rtl/regfile_lx_if.sv | 48 ++++
 rtl/regfile_lx.sv | 184 ++++++++++++++++++
 tb/tb_regfile_lx.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_lx_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_lx_if
//  Description : Bus bundle between decode/writeback (master side) and the
//                regfile_lx register file (slave side). It carries the read
//                ports, the write/link ports, the scoreboard set port and
//                the status outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_lx_if #(
    parameter int ADDR_W = 5
);
    // Read side (decode)
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [31:0]       busA;
    logic [31:0]       busB;
    logic [29:0]       jalpc;
    logic              busyA;
    logic              busyB;

    // Write side (writeback)
    logic [ADDR_W-1:0] rw;
    logic [5:0]        op;
    logic [1:0]        addr;
    logic              regWe;
    logic              r31We;
    logic [29:0]       r31;
    logic [31:0]       busW;
    logic              addrErr;

    // Scoreboard set (decode, when a load issues)
    logic              sbSet;
    logic [ADDR_W-1:0] sbIdx;

    // Pipeline side: drives indices and write data, consumes read data
    modport master (
        output rs, rt, rw, op, addr, regWe, r31We, r31, busW, sbSet, sbIdx,
        input  busA, busB, jalpc, busyA, busyB, addrErr
    );

    // Register file side
    modport slave (
        input  rs, rt, rw, op, addr, regWe, r31We, r31, busW, sbSet, sbIdx,
        output busA, busB, jalpc, busyA, busyB, addrErr
    );
endinterface
`default_nettype wire

// File: rtl/regfile_lx.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_lx
//  Description : Parametrised register file with two combinational read
//                ports, a jump-register target output, one write port with
//                a load-extract unit (lb/lbu/lh/lhu/lw), a link-register
//                write for jal and a per-register pending-load scoreboard.
//                Optional macro REGFILE_BYPASS_EN enables same-cycle
//                write-to-read bypass on both read ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_lx #(
    parameter int ADDR_W   = 5,
    parameter int LINK_REG = 31,
    parameter int R0_ZERO  = 1
) (
    input  wire         clk,
    input  wire         rst,
    regfile_lx_if.slave bus
);

    localparam int                NREG     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LINK_IDX = LINK_REG[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] IDX_ZERO = '0;
    localparam bit                R0Z      = (R0_ZERO != 0);

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;

    // State
    logic [31:0]     regs_q [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            addr_err_q;
    logic            addr_err_d;

    // Write-path wires
    logic [31:0] wdata;
    logic        is_half;
    logic        misaligned;
    logic        wr_en;
    logic        link_en;
    logic [31:0] link_val;

    assign is_half    = (bus.op == OP_LH) || (bus.op == OP_LHU);
    assign misaligned = bus.regWe && is_half && bus.addr[0];
    // Misaligned halfwords and (optionally) r0 writes are dropped here
    assign wr_en      = bus.regWe && !misaligned && !(R0Z && (bus.rw == IDX_ZERO));
    assign link_en    = bus.r31We && !(R0Z && (LINK_IDX == IDX_ZERO));
    assign link_val   = {bus.r31, 2'b00};

    // Load extraction: select byte/halfword lane from busW and extend
    always_comb begin
        logic [7:0]  byte_sel;
        logic [15:0] half_sel;
        byte_sel = bus.busW[8*bus.addr +: 8];
        half_sel = bus.addr[1] ? bus.busW[31:16] : bus.busW[15:0];
        wdata    = bus.busW;
        case (bus.op)
            OP_LB:   wdata = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  wdata = {24'd0, byte_sel};
            OP_LH:   wdata = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  wdata = {16'd0, half_sel};
            default: wdata = bus.busW;
        endcase
    end

    // Scoreboard next state: clear on writeback, then set (set wins)
    always_comb begin
        busy_d = busy_q;
        if (bus.regWe) begin
            busy_d[bus.rw] = 1'b0;
        end
        if (bus.sbSet) begin
            busy_d[bus.sbIdx] = 1'b1;
        end
        if (R0Z) begin
            busy_d[0] = 1'b0;
        end
        addr_err_d = misaligned;
    end

    // Register array commit; the link write is ordered last so it wins
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                regs_q[bus.rw] <= wdata;
            end
            if (link_en) begin
                regs_q[LINK_IDX] <= link_val;
            end
        end
    end

    // Scoreboard and misaligned-access pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q     <= '0;
            addr_err_q <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Read ports
    logic [31:0] rd_a;
    logic [31:0] rd_b;
    logic        bsy_a;
    logic        bsy_b;

`ifdef REGFILE_BYPASS_EN
    // Bypassed read A: link beats regular write beats committed state
    always_comb begin
        if (R0Z && (bus.rs == IDX_ZERO)) begin
            rd_a = '0;
        end else if (link_en && (bus.rs == LINK_IDX)) begin
            rd_a = link_val;
        end else if (wr_en && (bus.rs == bus.rw)) begin
            rd_a = wdata;
        end else begin
            rd_a = regs_q[bus.rs];
        end
        bsy_a = busy_q[bus.rs]
              & ~(bus.regWe && (bus.rw == bus.rs) && !(bus.sbSet && (bus.sbIdx == bus.rs)));
        if (R0Z && (bus.rs == IDX_ZERO)) begin
            bsy_a = 1'b0;
        end
    end

    // Bypassed read B: same priority as port A
    always_comb begin
        if (R0Z && (bus.rt == IDX_ZERO)) begin
            rd_b = '0;
        end else if (link_en && (bus.rt == LINK_IDX)) begin
            rd_b = link_val;
        end else if (wr_en && (bus.rt == bus.rw)) begin
            rd_b = wdata;
        end else begin
            rd_b = regs_q[bus.rt];
        end
        bsy_b = busy_q[bus.rt]
              & ~(bus.regWe && (bus.rw == bus.rt) && !(bus.sbSet && (bus.sbIdx == bus.rt)));
        if (R0Z && (bus.rt == IDX_ZERO)) begin
            bsy_b = 1'b0;
        end
    end
`else
    // Committed-state read A
    always_comb begin
        rd_a  = regs_q[bus.rs];
        bsy_a = busy_q[bus.rs];
        if (R0Z && (bus.rs == IDX_ZERO)) begin
            rd_a  = '0;
            bsy_a = 1'b0;
        end
    end

    // Committed-state read B
    always_comb begin
        rd_b  = regs_q[bus.rt];
        bsy_b = busy_q[bus.rt];
        if (R0Z && (bus.rt == IDX_ZERO)) begin
            rd_b  = '0;
            bsy_b = 1'b0;
        end
    end
`endif

    assign bus.busA    = rd_a;
    assign bus.busB    = rd_b;
    assign bus.jalpc   = rd_a[31:2];
    assign bus.busyA   = bsy_a;
    assign bus.busyB   = bsy_b;
    assign bus.addrErr = addr_err_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_lx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_lx
//  Description : Directed self-checking bench for regfile_lx. Expected values
//                are queued when a step is driven and popped when the DUT
//                output is sampled.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_lx;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LW  = 6'b100011;

    logic clk;
    logic rst;

    regfile_lx_if #(.ADDR_W(5)) bus ();

    regfile_lx #(
        .ADDR_W   (5),
        .LINK_REG (31),
        .R0_ZERO  (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] exp_q [$];
    string       tag_q [$];
    int          checks;
    int          errors;

    // Queue an expected value at stimulus time
    task automatic expect_val(input string tag, input logic [31:0] val);
        exp_q.push_back(val);
        tag_q.push_back(tag);
    endtask

    // Pop the oldest expectation and compare it with the observed output
    task automatic compare(input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: observed %h, no expectation queued", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", t, obs, e);
            end
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.regWe = 1'b0;
        bus.r31We = 1'b0;
        bus.sbSet = 1'b0;
        bus.op    = 6'd0;
        bus.addr  = 2'd0;
    endtask

    task automatic write_reg(input logic [4:0] idx, input logic [5:0] o,
                             input logic [1:0] a, input logic [31:0] d);
        bus.rw    = idx;
        bus.op    = o;
        bus.addr  = a;
        bus.busW  = d;
        bus.regWe = 1'b1;
        tick();
        idle();
    endtask

    task automatic read_a(input logic [4:0] idx);
        bus.rs = idx;
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.rs = '0; bus.rt = '0; bus.rw = '0; bus.sbIdx = '0;
        bus.r31 = '0; bus.busW = '0;
        idle();
        tick();
        rst = 1'b0;

        // Preload and reset
        write_reg(5'd5, 6'd0, 2'd0, 32'h12345678);
        read_a(5'd5);
        expect_val("preload_r5", 32'h12345678);
        compare(bus.busA);

        rst = 1'b1;
        bus.rw = 5'd6; bus.busW = 32'h55; bus.regWe = 1'b1; bus.sbSet = 1'b1; bus.sbIdx = 5'd6;
        tick();
        rst = 1'b0;
        idle();
        bus.rs = 5'd5; bus.rt = 5'd6;
        #1;
        expect_val("reset_r5", 32'h0);
        compare(bus.busA);
        expect_val("reset_no_write_r6", 32'h0);
        compare(bus.busB);
        expect_val("reset_busyB", 32'h0);
        compare({31'd0, bus.busyB});
        expect_val("reset_addrErr", 32'h0);
        compare({31'd0, bus.addrErr});

        // Load extraction
        write_reg(5'd10, OP_LB, 2'd3, 32'h80FF7F01);
        read_a(5'd10);
        expect_val("lb_a3", 32'hFFFFFF80);
        compare(bus.busA);
        write_reg(5'd10, OP_LBU, 2'd3, 32'h80FF7F01);
        read_a(5'd10);
        expect_val("lbu_a3", 32'h00000080);
        compare(bus.busA);
        write_reg(5'd11, OP_LB, 2'd1, 32'h80FF7F01);
        read_a(5'd11);
        expect_val("lb_a1", 32'h0000007F);
        compare(bus.busA);
        write_reg(5'd10, OP_LH, 2'd2, 32'h80FF7F01);
        read_a(5'd10);
        expect_val("lh_a2", 32'hFFFF80FF);
        compare(bus.busA);
        write_reg(5'd10, OP_LHU, 2'd0, 32'h80FF7F01);
        read_a(5'd10);
        expect_val("lhu_a0", 32'h00007F01);
        compare(bus.busA);
        write_reg(5'd10, OP_LHU, 2'd2, 32'h80FF7F01);
        read_a(5'd10);
        expect_val("lhu_a2", 32'h000080FF);
        compare(bus.busA);
        write_reg(5'd10, OP_LW, 2'd0, 32'h80FF7F01);
        read_a(5'd10);
        expect_val("lw", 32'h80FF7F01);
        compare(bus.busA);

        // Misaligned halfword
        write_reg(5'd7, 6'd0, 2'd0, 32'hAAAAAAAA);
        bus.sbSet = 1'b1; bus.sbIdx = 5'd7;
        tick();
        idle();
        read_a(5'd7);
        expect_val("busy7_set", 32'h1);
        compare({31'd0, bus.busyA});
        write_reg(5'd7, OP_LH, 2'd1, 32'h12345678);
        read_a(5'd7);
        expect_val("misaligned_no_write", 32'hAAAAAAAA);
        compare(bus.busA);
        expect_val("misaligned_busy_clr", 32'h0);
        compare({31'd0, bus.busyA});
        expect_val("misaligned_addrErr", 32'h1);
        compare({31'd0, bus.addrErr});
        tick();
        expect_val("addrErr_one_cycle", 32'h0);
        compare({31'd0, bus.addrErr});

        // R0 and link
        write_reg(5'd0, 6'd0, 2'd0, 32'hDEADBEEF);
        bus.sbSet = 1'b1; bus.sbIdx = 5'd0;
        tick();
        idle();
        read_a(5'd0);
        expect_val("r0_zero", 32'h0);
        compare(bus.busA);
        expect_val("r0_busy_zero", 32'h0);
        compare({31'd0, bus.busyA});

        bus.rw = 5'd31; bus.busW = 32'd5; bus.regWe = 1'b1;
        bus.r31We = 1'b1; bus.r31 = 30'h3FFFFFFF;
        tick();
        idle();
        read_a(5'd31);
        expect_val("link_wins", 32'hFFFFFFFC);
        compare(bus.busA);
        expect_val("jalpc", 32'h3FFFFFFF);
        compare({2'd0, bus.jalpc});

        // Scoreboard
        bus.sbSet = 1'b1; bus.sbIdx = 5'd9;
        tick();
        idle();
        read_a(5'd9);
        expect_val("sb_set9", 32'h1);
        compare({31'd0, bus.busyA});
        write_reg(5'd9, 6'd0, 2'd0, 32'h99);
        read_a(5'd9);
        expect_val("sb_clr9", 32'h0);
        compare({31'd0, bus.busyA});
        bus.rw = 5'd9; bus.busW = 32'h1234; bus.regWe = 1'b1;
        bus.sbSet = 1'b1; bus.sbIdx = 5'd9;
        tick();
        idle();
        read_a(5'd9);
        expect_val("sb_set_wins", 32'h1);
        compare({31'd0, bus.busyA});
        expect_val("sb_same_cycle_write", 32'h1234);
        compare(bus.busA);
        bus.rw = 5'd13; bus.busW = 32'h13; bus.regWe = 1'b1;
        bus.sbSet = 1'b1; bus.sbIdx = 5'd12;
        tick();
        idle();
        bus.rs = 5'd12; bus.rt = 5'd13;
        #1;
        expect_val("sb_indep_12", 32'h1);
        compare({31'd0, bus.busyA});
        expect_val("sb_indep_13", 32'h0);
        compare({31'd0, bus.busyB});
        expect_val("write_indep_13", 32'h13);
        compare(bus.busB);

        // Same-cycle write/read visibility
        write_reg(5'd4, 6'd0, 2'd0, 32'h22);
        bus.rs = 5'd4; bus.rw = 5'd4; bus.busW = 32'h11; bus.regWe = 1'b1;
        #1;
`ifdef REGFILE_BYPASS_EN
        expect_val("bypass_pre_edge", 32'h11);
`else
        expect_val("no_bypass_pre_edge", 32'h22);
`endif
        compare(bus.busA);
        tick();
        idle();
        #1;
        expect_val("post_edge_r4", 32'h11);
        compare(bus.busA);

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: observed %0d entries, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
